// File: rtl/rgb_gray_frame_if.sv
// Register-side bundle of the RGB-to-gray frame subsystem: slave-register
// commands in, read data and status pulses out.
interface rgb_gray_frame_if #(
  parameter int COLOR_W = 12,
  parameter int GRAY_W  = 8
);
  logic               wr_to_slave_reg_en;
  logic [31:0]        axi_slave_r0;
  logic [31:0]        axi_slave_r1;
  logic [31:0]        axi_slave_r3;
  logic [COLOR_W-1:0] color_rdata;
  logic               color_rdata_valid;
  logic [GRAY_W-1:0]  gray_rdata;
  logic               gray_rdata_valid;
  logic [1:0]         state;
  logic               done_write_color;
  logic               done_write_gray;
  logic               done_read_gray;

  modport master (
    output wr_to_slave_reg_en, axi_slave_r0, axi_slave_r1, axi_slave_r3,
    input  color_rdata, color_rdata_valid, gray_rdata, gray_rdata_valid,
    input  state, done_write_color, done_write_gray, done_read_gray
  );

  modport slave (
    input  wr_to_slave_reg_en, axi_slave_r0, axi_slave_r1, axi_slave_r3,
    output color_rdata, color_rdata_valid, gray_rdata, gray_rdata_valid,
    output state, done_write_color, done_write_gray, done_read_gray
  );
endinterface

// File: rtl/rgb_gray_frame_subsystem.sv
// Frame-buffer front end: register bridge, colour BRAM, RGB444-to-gray
// converter, gray BRAM and the FSM that arbitrates BRAM ownership.
module rgb_gray_frame_subsystem #(
  parameter int FRAME_PIXELS = 76800,
  parameter int COLOR_W      = 12,
  parameter int GRAY_W       = 8
) (
  input logic            clk,
  input logic            rst_n,
  rgb_gray_frame_if.slave bus
);
  localparam int          LOC_W     = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [16:0] FRAME_SZ  = 17'(FRAME_PIXELS);
  localparam logic [16:0] LAST_ADDR = 17'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    AXI_WRITE    = 2'd1,
    RGB_OCCUPIED = 2'd2,
    AXI_READ     = 2'd3
  } state_t;

  state_t state_reg;

  logic               wren_d_reg, cwr_stb_reg, crd_stb_reg, grd_stb_reg;
  logic [16:0]        caddr_reg, gaddr_reg;
  logic [COLOR_W-1:0] cwdata_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wren_d_reg  <= 1'b0;
      cwr_stb_reg <= 1'b0;
      crd_stb_reg <= 1'b0;
      grd_stb_reg <= 1'b0;
      caddr_reg   <= '0;
      gaddr_reg   <= '0;
      cwdata_reg  <= '0;
    end else begin
      wren_d_reg  <= bus.wr_to_slave_reg_en;
      cwr_stb_reg <= wren_d_reg && bus.axi_slave_r0[18] && bus.axi_slave_r0[17];
      crd_stb_reg <= wren_d_reg && bus.axi_slave_r0[18] && !bus.axi_slave_r0[17];
      grd_stb_reg <= wren_d_reg && bus.axi_slave_r3[31];
      if (wren_d_reg) begin
        caddr_reg  <= bus.axi_slave_r0[16:0];
        gaddr_reg  <= bus.axi_slave_r3[24:8];
        cwdata_reg <= {bus.axi_slave_r1[23:20], bus.axi_slave_r1[15:12], bus.axi_slave_r1[7:4]};
      end
    end
  end

  logic              conv_busy_reg, rd_vld_reg, gw_en_reg;
  logic [16:0]       conv_addr_reg, rd_addr_reg, gw_addr_reg;
  logic [GRAY_W-1:0] gw_data_reg;

  // While the converter owns the BRAMs every bridge command is discarded.
  logic        occupied;
  logic [16:0] c_addr, g_addr;
  logic        c_we, c_re, g_we, g_re, c_in_range, g_in_range;
  assign occupied = (state_reg == RGB_OCCUPIED);

  always_comb begin
    c_addr = caddr_reg;
    c_we   = cwr_stb_reg;
    c_re   = crd_stb_reg;
    g_addr = gaddr_reg;
    g_we   = 1'b0;
    g_re   = grd_stb_reg;
    if (occupied) begin
      c_addr = conv_addr_reg;
      c_we   = 1'b0;
      c_re   = conv_busy_reg;
      g_addr = gw_addr_reg;
      g_we   = gw_en_reg;
      g_re   = 1'b0;
    end
  end

  assign c_in_range = (c_addr < FRAME_SZ);
  assign g_in_range = (g_addr < FRAME_SZ);

  logic [COLOR_W-1:0] color_mem [FRAME_PIXELS];
  logic [GRAY_W-1:0]  gray_mem  [FRAME_PIXELS];
  logic [COLOR_W-1:0] color_q_reg;
  logic [GRAY_W-1:0]  gray_q_reg;

  always_ff @(posedge clk) begin
    if (c_we && c_in_range) color_mem[c_addr[LOC_W-1:0]] <= cwdata_reg;
    if (c_re) color_q_reg <= color_mem[c_addr[LOC_W-1:0]];
    if (g_we && g_in_range) gray_mem[g_addr[LOC_W-1:0]] <= gw_data_reg;
    if (g_re) gray_q_reg <= gray_mem[g_addr[LOC_W-1:0]];
  end

  // Out-of-range reads are masked to zero after the array read register.
  logic color_range_reg, gray_range_reg, color_valid_reg, gray_valid_reg;
  logic done_wc_reg, done_wg_reg, done_rg_reg;
  logic [16:0] grd_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      color_range_reg <= 1'b0;
      gray_range_reg  <= 1'b0;
      color_valid_reg <= 1'b0;
      gray_valid_reg  <= 1'b0;
      done_wc_reg     <= 1'b0;
      done_wg_reg     <= 1'b0;
      done_rg_reg     <= 1'b0;
      grd_cnt_reg     <= '0;
    end else begin
      if (c_re) color_range_reg <= c_in_range;
      if (g_re) gray_range_reg  <= g_in_range;
      color_valid_reg <= c_re && !occupied;
      gray_valid_reg  <= g_re && !occupied;
      done_wc_reg     <= c_we && (c_addr == LAST_ADDR);
      done_wg_reg     <= g_we && (g_addr == LAST_ADDR);
      done_rg_reg     <= 1'b0;
      if (grd_stb_reg && state_reg == AXI_READ) begin
        if (grd_cnt_reg == LAST_ADDR) begin
          grd_cnt_reg <= '0;
          done_rg_reg <= 1'b1;
        end else begin
          grd_cnt_reg <= grd_cnt_reg + 17'd1;
        end
      end
    end
  end

  logic [7:0]  r8, g8, b8;
  logic [17:0] gray_sum;
  assign r8       = {color_q_reg[11:8], color_q_reg[11:8]};
  assign g8       = {color_q_reg[7:4], color_q_reg[7:4]};
  assign b8       = {color_q_reg[3:0], color_q_reg[3:0]};
  assign gray_sum = 18'd77 * {10'd0, r8} + 18'd150 * {10'd0, g8} + 18'd29 * {10'd0, b8};

  // Read k in cycle t, colour data in t+1, gray write of k in t+2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_busy_reg <= 1'b0;
      conv_addr_reg <= '0;
      rd_vld_reg    <= 1'b0;
      rd_addr_reg   <= '0;
      gw_en_reg     <= 1'b0;
      gw_addr_reg   <= '0;
      gw_data_reg   <= '0;
    end else begin
      rd_vld_reg  <= conv_busy_reg;
      rd_addr_reg <= conv_addr_reg;
      gw_en_reg   <= rd_vld_reg;
      gw_addr_reg <= rd_addr_reg;
      gw_data_reg <= gray_sum[15:8];
      if (conv_busy_reg) begin
        if (conv_addr_reg == LAST_ADDR) conv_busy_reg <= 1'b0;
        else                            conv_addr_reg <= conv_addr_reg + 17'd1;
      end else if (done_wc_reg && state_reg == AXI_WRITE) begin
        conv_busy_reg <= 1'b1;
        conv_addr_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:         if (bus.axi_slave_r0[18]) state_reg <= AXI_WRITE;
        AXI_WRITE:    if (done_wc_reg)          state_reg <= RGB_OCCUPIED;
        RGB_OCCUPIED: if (done_wg_reg)          state_reg <= AXI_READ;
        AXI_READ:     if (done_rg_reg)          state_reg <= IDLE;
        default:                                state_reg <= IDLE;
      endcase
    end
  end

  assign bus.color_rdata       = color_range_reg ? color_q_reg : '0;
  assign bus.color_rdata_valid = color_valid_reg;
  assign bus.gray_rdata        = gray_range_reg ? gray_q_reg : '0;
  assign bus.gray_rdata_valid  = gray_valid_reg;
  assign bus.state             = state_reg;
  assign bus.done_write_color  = done_wc_reg;
  assign bus.done_write_gray   = done_wg_reg;
  assign bus.done_read_gray    = done_rg_reg;

  logic unused_bits;
  assign unused_bits = ^{bus.axi_slave_r0[31:19], bus.axi_slave_r1[31:24], bus.axi_slave_r1[19:16],
                         bus.axi_slave_r1[11:8], bus.axi_slave_r1[3:0], bus.axi_slave_r3[30:25],
                         bus.axi_slave_r3[7:0], gray_sum[17:16], gray_sum[7:0]};
endmodule

// File: tb/tb_rgb_gray_frame_subsystem.sv
// Scoreboard bench for rgb_gray_frame_subsystem on a reduced 8-pixel frame
// with hand-computed colour and gray values.
module tb_rgb_gray_frame_subsystem;
  localparam int FRAME = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rgb_gray_frame_if #(.COLOR_W(12), .GRAY_W(8)) bus ();

  rgb_gray_frame_subsystem #(.FRAME_PIXELS(FRAME), .COLOR_W(12), .GRAY_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] data;
    int          addr;
    int          cyc;
  } exp_t;

  exp_t cq[$];
  exp_t gq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dwc_cnt = 0, dwg_cnt = 0, drg_cnt = 0;

  // RGB888 inputs and their gray results, worked by hand from the nibbles.
  logic [23:0] pix_rgb  [FRAME] = '{24'h101010, 24'hF00000, 24'h00F000, 24'h0000F0,
                                    24'hF0F0F0, 24'h000000, 24'h808080, 24'h2F3C4D};
  logic [7:0]  pix_gray [FRAME] = '{8'h11, 8'h4C, 8'h95, 8'h1C, 8'hFF, 8'h00, 8'h88, 8'h2F};

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic cmd(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r3, output int issue);
    @(posedge clk); #1;
    bus.axi_slave_r0 = r0;
    bus.axi_slave_r1 = r1;
    bus.axi_slave_r3 = r3;
    bus.wr_to_slave_reg_en = 1'b1;
    issue = cyc;
    @(posedge clk); #1;
    bus.wr_to_slave_reg_en = 1'b0;
  endtask

  task automatic color_write(input int addr, input logic [23:0] rgb);
    int c;
    cmd(32'h0006_0000 | 32'(addr), {8'h00, rgb}, 32'h0, c);
    $display("cmd color write addr=%0d rgb=%06h cyc=%0d", addr, rgb, c);
  endtask

  task automatic color_read(input int addr, input logic [11:0] want);
    int c;
    exp_t e;
    cmd(32'h0004_0000 | 32'(addr), 32'h0, 32'h0, c);
    e.data = want; e.addr = addr; e.cyc = c;
    cq.push_back(e);
  endtask

  task automatic gray_read(input int addr, input logic [7:0] want);
    int c;
    exp_t e;
    cmd(32'h0, 32'h0, 32'h8000_0000 | (32'(addr) << 8), c);
    e.data = {4'h0, want}; e.addr = addr; e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (bus.state == s) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL %s state=%0d want=%0d", name, bus.state, s);
    end
  endtask

  // Monitor: pops one expectation per valid pulse and checks data and latency.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.color_rdata_valid === 1'b1) begin
      checks++;
      if (cq.size() == 0) begin
        failures++;
        $display("FAIL color_unexpected got=%03h want=no_response", bus.color_rdata);
      end else begin
        e = cq.pop_front();
        if (bus.color_rdata !== e.data) begin
          failures++;
          $display("FAIL color_data addr=%0d got=%03h want=%03h", e.addr, bus.color_rdata, e.data);
        end else begin
          $display("color read addr=%0d data=%03h", e.addr, bus.color_rdata);
        end
        checks++;
        if (cyc - e.cyc != 3) begin
          failures++;
          $display("FAIL color_latency addr=%0d got=%0d want=3", e.addr, cyc - e.cyc);
        end
      end
    end
    if (bus.gray_rdata_valid === 1'b1) begin
      checks++;
      if (gq.size() == 0) begin
        failures++;
        $display("FAIL gray_unexpected got=%02h want=no_response", bus.gray_rdata);
      end else begin
        e = gq.pop_front();
        if (bus.gray_rdata !== e.data[7:0]) begin
          failures++;
          $display("FAIL gray_data addr=%0d got=%02h want=%02h", e.addr, bus.gray_rdata, e.data[7:0]);
        end else begin
          $display("gray read addr=%0d data=%02h", e.addr, bus.gray_rdata);
        end
        checks++;
        if (cyc - e.cyc != 3) begin
          failures++;
          $display("FAIL gray_latency addr=%0d got=%0d want=3", e.addr, cyc - e.cyc);
        end
      end
    end
    if (bus.done_write_color === 1'b1) dwc_cnt++;
    if (bus.done_write_gray === 1'b1)  dwg_cnt++;
    if (bus.done_read_gray === 1'b1)   drg_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    bus.wr_to_slave_reg_en = 1'b0;
    bus.axi_slave_r0 = '0;
    bus.axi_slave_r1 = '0;
    bus.axi_slave_r3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_color_valid", 32'(bus.color_rdata_valid), 32'd0);
    chk("rst_gray_valid", 32'(bus.gray_rdata_valid), 32'd0);
    chk("rst_done_wc", 32'(bus.done_write_color), 32'd0);
    chk("rst_done_wg", 32'(bus.done_write_gray), 32'd0);
    chk("rst_done_rg", 32'(bus.done_read_gray), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    color_write(0, pix_rgb[0]);
    wait_state(2'd1, 8, "state_axi_write");
    color_read(0, 12'h111);

    // Out-of-range address: write dropped, reads return zero, no done pulse.
    color_write(FRAME, 24'hFFFFFF);
    color_read(FRAME, 12'h000);
    gray_read(FRAME, 8'h00);
    repeat (4) @(negedge clk);
    chk("boundary_no_done_wc", 32'(dwc_cnt), 32'd0);

    for (int i = 1; i < FRAME; i++) color_write(i, pix_rgb[i]);
    wait_state(2'd2, 10, "state_rgb_occupied");
    chk("done_wc_count", 32'(dwc_cnt), 32'd1);

    // Colour write and gray read issued while the converter owns the BRAMs.
    cmd(32'h0006_0000, 32'h00F0F0F0, 32'h8000_0000, c);
    $display("cmd dropped write+gray read during conversion cyc=%0d", c);

    wait_state(2'd3, FRAME + 40, "state_axi_read");
    chk("done_wg_count", 32'(dwg_cnt), 32'd1);
    bus.axi_slave_r0 = '0;

    color_read(0, 12'h111);
    color_read(1, 12'hF00);
    for (int i = 0; i < FRAME; i++) gray_read(i, pix_gray[i]);
    wait_state(2'd0, 10, "state_idle_after_read");
    chk("done_rg_count", 32'(drg_cnt), 32'd1);

    for (int i = 0; i < 20 && (cq.size() != 0 || gq.size() != 0); i++) @(negedge clk);
    chk("color_queue_drained", 32'(cq.size()), 32'd0);
    chk("gray_queue_drained", 32'(gq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
